// File: rtl/buzzer_sched.sv
// buzzer_sched: shares one piezo among alarm, hourly chime and key-click requesters,
// sequencing the alarm ring pattern and gating a per-source square-wave tone onto the pin.
module buzzer_sched #(
   parameter int TONE_DIV_ALARM = 25000,
   parameter int TONE_DIV_CHIME = 50000,
   parameter int TONE_DIV_KEY   = 12500,
   parameter int BEEP_LEN       = 5000000,
   parameter int ALARM_SECS     = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       chime_req,
   input  logic       alarm_match,
   input  logic       alarm_en,
   input  logic       stop_btn,
   input  logic       key_beep,
   output logic       buzzer,
   output logic [1:0] active_src,
   output logic       alarm_ringing
);

   localparam int TONE_MAX_AC = (TONE_DIV_ALARM > TONE_DIV_CHIME) ? TONE_DIV_ALARM : TONE_DIV_CHIME;
   localparam int TONE_MAX    = (TONE_MAX_AC > TONE_DIV_KEY) ? TONE_MAX_AC : TONE_DIV_KEY;
   localparam int TONE_W      = $clog2(TONE_MAX);
   localparam int BEEP_W      = $clog2(BEEP_LEN + 1);
   localparam int SEC_W       = $clog2(ALARM_SECS + 1);

   // State encoding doubles as the active_src code.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_KEY   = 2'd1,
      S_CHIME = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   state_t              r_state;
   logic [TONE_W-1:0]   r_tone_cnt;
   logic                r_tone_bit;
   logic [BEEP_W-1:0]   r_beep_cnt;
   logic [SEC_W-1:0]    r_sec_cnt;
   logic                r_gate;

   state_t              w_next;
   logic [TONE_W-1:0]   w_div_m1;
   logic                w_alarm_start;
   logic                w_beep_last;
   logic                w_sec_last;
   logic                w_state_chg;

   assign w_alarm_start = alarm_match & alarm_en & ~stop_btn & (r_state != S_ALARM);
   assign w_beep_last   = (r_beep_cnt == BEEP_W'(BEEP_LEN - 1));
   assign w_sec_last    = (r_sec_cnt == SEC_W'(ALARM_SECS - 1));
   assign w_state_chg   = (w_next != r_state);

   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_alarm_start)  w_next = S_ALARM;
            else if (chime_req) w_next = S_CHIME;
            else if (key_beep)  w_next = S_KEY;
         end
         S_KEY: begin
            if (w_alarm_start)                  w_next = S_ALARM;
            else if (chime_req)                 w_next = S_CHIME;
            else if (!key_beep && w_beep_last)  w_next = S_IDLE;
         end
         S_CHIME: begin
            if (w_alarm_start)   w_next = S_ALARM;
            else if (!chime_req) w_next = S_IDLE;
         end
         S_ALARM: begin
            // Stop outranks a coincident tick; a pending chime takes over on exit.
            if (stop_btn || (tick_1hz && w_sec_last))
               w_next = chime_req ? S_CHIME : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_div_m1 = '0;
      case (r_state)
         S_ALARM: w_div_m1 = TONE_W'(TONE_DIV_ALARM - 1);
         S_CHIME: w_div_m1 = TONE_W'(TONE_DIV_CHIME - 1);
         S_KEY:   w_div_m1 = TONE_W'(TONE_DIV_KEY - 1);
         default: w_div_m1 = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_tone_cnt    <= '0;
         r_tone_bit    <= 1'b0;
         r_beep_cnt    <= '0;
         r_sec_cnt     <= '0;
         r_gate        <= 1'b0;
         buzzer        <= 1'b0;
         active_src    <= 2'd0;
         alarm_ringing <= 1'b0;
      end else begin
         r_state       <= w_next;
         active_src    <= w_next;
         alarm_ringing <= (w_next == S_ALARM);
         buzzer        <= (w_next != S_IDLE) & r_tone_bit & r_gate;

         // Tone restarts from a low phase on every source change and rests in IDLE.
         if (w_state_chg || w_next == S_IDLE) begin
            r_tone_cnt <= '0;
            r_tone_bit <= 1'b0;
         end else if (r_tone_cnt == w_div_m1) begin
            r_tone_cnt <= '0;
            r_tone_bit <= ~r_tone_bit;
         end else begin
            r_tone_cnt <= r_tone_cnt + 1'b1;
         end

         case (w_next)
            S_KEY: begin
               r_gate <= 1'b1;
               if (w_state_chg || key_beep) r_beep_cnt <= '0;
               else                         r_beep_cnt <= r_beep_cnt + 1'b1;
            end
            S_ALARM: begin
               if (w_state_chg) begin
                  r_sec_cnt <= '0;
                  r_gate    <= 1'b1;
               end else if (tick_1hz) begin
                  r_sec_cnt <= r_sec_cnt + 1'b1;
                  r_gate    <= ~r_gate;
               end
            end
            S_CHIME: r_gate <= chime_req;
            default: begin
               r_gate     <= 1'b0;
               r_beep_cnt <= '0;
               r_sec_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buzzer_sched.sv
// Scoreboard bench for buzzer_sched: each scenario pushes the expected registered outputs
// for the coming edge, and step() pops and compares them just after that edge.
module tb_buzzer_sched;

   localparam int DIV_A       = 4;
   localparam int DIV_C       = 8;
   localparam int DIV_K       = 2;
   localparam int BEEP        = 10;
   localparam int SECS        = 4;
   localparam int TICK_PERIOD = 100;

   typedef struct packed {
      logic       buz;
      logic [1:0] src;
      logic       ring;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic       chime_req = 1'b0;
   logic       alarm_match = 1'b0;
   logic       alarm_en = 1'b0;
   logic       stop_btn = 1'b0;
   logic       key_beep = 1'b0;
   logic       buzzer;
   logic [1:0] active_src;
   logic       alarm_ringing;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   buzzer_sched #(
      .TONE_DIV_ALARM (DIV_A),
      .TONE_DIV_CHIME (DIV_C),
      .TONE_DIV_KEY   (DIV_K),
      .BEEP_LEN       (BEEP),
      .ALARM_SECS     (SECS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tick_1hz      (tick_1hz),
      .chime_req     (chime_req),
      .alarm_match   (alarm_match),
      .alarm_en      (alarm_en),
      .stop_btn      (stop_btn),
      .key_beep      (key_beep),
      .buzzer        (buzzer),
      .active_src    (active_src),
      .alarm_ringing (alarm_ringing)
   );

   always #5 clk = ~clk;

   // Tone bit n edges after a source (re)started with half-period div.
   function automatic logic tone(input int n, input int div);
      return ((n / div) % 2) == 1;
   endfunction

   // Alarm gate n edges after ring start: on for the first second, then alternating.
   function automatic logic on_sec(input int n);
      return ((n / TICK_PERIOD) % 2) == 0;
   endfunction

   task automatic push(input logic b, input logic [1:0] s, input logic r);
      exp_t e;
      e.buz  = b;
      e.src  = s;
      e.ring = r;
      exp_q.push_back(e);
   endtask

   task automatic step(input string name, input int j);
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      got.buz  = buzzer;
      got.src  = active_src;
      got.ring = alarm_ringing;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_miss++;
         $display("FAIL %s cyc %0d: no expectation queued, got buz=%b src=%0d ring=%b",
                  name, j, got.buz, got.src, got.ring);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            n_miss++;
            $display("FAIL %s cyc %0d: got buz=%b src=%0d ring=%b, expected buz=%b src=%0d ring=%b",
                     name, j, got.buz, got.src, got.ring, e.buz, e.src, e.ring);
         end
      end
   endtask

   task automatic clear_inputs();
      rst = 1'b0; tick_1hz = 1'b0; chime_req = 1'b0; alarm_match = 1'b0;
      alarm_en = 1'b0; stop_btn = 1'b0; key_beep = 1'b0;
   endtask

   task automatic test_reset();
      for (int j = 0; j < 6; j++) begin
         rst = (j < 3);
         push(1'b0, 2'd0, 1'b0);
         step("reset", j);
      end
      clear_inputs();
   endtask

   task automatic test_key();
      for (int j = 0; j < 13; j++) begin
         key_beep = (j == 0);
         push((j >= 1 && j < BEEP) ? tone(j - 1, DIV_K) : 1'b0,
              (j < BEEP) ? 2'd1 : 2'd0, 1'b0);
         step("key", j);
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      // Second click at edge 5 restarts the length but not the tone phase.
      for (int j = 0; j < 18; j++) begin
         key_beep = (j == 0 || j == 5);
         push((j >= 1 && j < 5 + BEEP) ? tone(j - 1, DIV_K) : 1'b0,
              (j < 5 + BEEP) ? 2'd1 : 2'd0, 1'b0);
         step("key_restart", j);
      end
      clear_inputs();
   endtask

   task automatic test_chime();
      for (int j = 0; j < 256; j++) begin
         chime_req = (j < 250);
         key_beep  = (j == 100);
         push((j >= 1 && j < 250) ? tone(j - 1, DIV_C) : 1'b0,
              (j < 250) ? 2'd2 : 2'd0, 1'b0);
         step("chime", j);
      end
      clear_inputs();
   endtask

   task automatic test_alarm();
      int last = SECS * TICK_PERIOD;
      for (int j = 0; j < last + 5; j++) begin
         alarm_match = (j == 0);
         alarm_en    = 1'b1;
         tick_1hz    = (j > 0) && (j % TICK_PERIOD == 0);
         push((j >= 1 && j < last) ? (tone(j - 1, DIV_A) & on_sec(j - 1)) : 1'b0,
              (j < last) ? 2'd3 : 2'd0, (j < last));
         step("alarm", j);
      end
      clear_inputs();
   endtask

   task automatic test_stop();
      for (int j = 0; j < 190; j++) begin
         alarm_match = (j == 0);
         alarm_en    = (j == 0);
         tick_1hz    = (j == 100);
         chime_req   = (j >= 120 && j < 180);
         stop_btn    = (j == 150);
         if (j < 150)
            push((j >= 1) ? (tone(j - 1, DIV_A) & on_sec(j - 1)) : 1'b0, 2'd3, 1'b1);
         else if (j == 150)
            push(1'b0, 2'd2, 1'b0);
         else if (j < 180)
            push(tone(j - 151, DIV_C), 2'd2, 1'b0);
         else
            push(1'b0, 2'd0, 1'b0);
         step("stop", j);
      end
      clear_inputs();
   endtask

   task automatic test_preempt();
      for (int j = 0; j < 75; j++) begin
         chime_req   = (j < 70);
         alarm_match = (j == 20 || j == 41);
         alarm_en    = (j == 41);
         stop_btn    = (j == 60);
         if (j < 41)
            push((j >= 1) ? tone(j - 1, DIV_C) : 1'b0, 2'd2, 1'b0);
         else if (j == 41)
            push(tone(40, DIV_C), 2'd3, 1'b1);
         else if (j < 60)
            push(tone(j - 42, DIV_A), 2'd3, 1'b1);
         else if (j == 60)
            push(tone(18, DIV_A), 2'd2, 1'b0);
         else if (j < 70)
            push(tone(j - 61, DIV_C), 2'd2, 1'b0);
         else
            push(1'b0, 2'd0, 1'b0);
         step("preempt", j);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_alarm();
      for (int j = 0; j < 125; j++) begin
         alarm_match = (j == 0 || j == 115);
         alarm_en    = (j == 0 || j == 115);
         rst         = (j == 50);
         key_beep    = (j == 50);
         tick_1hz    = (j == 100);
         stop_btn    = (j == 115);
         if (j < 50)
            push((j >= 1) ? tone(j - 1, DIV_A) : 1'b0, 2'd3, 1'b1);
         else
            push(1'b0, 2'd0, 1'b0);
         step("reset_mid", j);
      end
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_key();
      test_back_to_back();
      test_chime();
      test_alarm();
      test_stop();
      test_preempt();
      test_reset_mid_alarm();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
- Single-buzzer scheduler for the digital clock.
- Shares one piezo output among three requesters:
  - user alarm-clock match (highest priority),
  - hourly chime pattern (from the chime generator's alarm/alarm2 levels),
  - key-click feedback (lowest priority).
- Sequences the alarm ring pattern and its timeout, handles the stop button, and generates a per-source square-wave tone gated onto the buzzer pin.

Parameters:
- TONE_DIV_ALARM, 25000, half-period of the alarm tone in clk cycles (≥2).
- TONE_DIV_CHIME, 50000, half-period of the chime tone in clk cycles (≥2).
- TONE_DIV_KEY, 12500, half-period of the key-click tone in clk cycles (≥2).
- BEEP_LEN, 5000000, key-click duration in clk cycles (≥1).
- ALARM_SECS, 60, alarm ring duration in tick_1hz pulses (≥1).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- tick_1hz, in, 1, one-cycle pulse once per second.
- chime_req, in, 1, level; high = chime generator wants sound (OR of alarm, alarm2).
- alarm_match, in, 1, one-cycle pulse when the current time equals the alarm setting.
- alarm_en, in, 1, alarm armed; sampled with alarm_match.
- stop_btn, in, 1, debounced one-cycle pulse; silences a ringing alarm.
- key_beep, in, 1, one-cycle pulse per accepted keypress.
- buzzer, out, 1, registered gated tone to the piezo.
- active_src, out, 2, registered: 0 idle, 1 key, 2 chime, 3 alarm.
- alarm_ringing, out, 1, registered; high while in state ALARM.

Behaviour:

Reset (rst=1 at a clk edge):
- state=IDLE; buzzer=0, active_src=0, alarm_ringing=0.
- tone counter=0, tone bit=0, beep counter=0, second counter=0, gate=0.
- Reset mid-ring aborts immediately. No request is remembered across reset.

States: IDLE, KEY, CHIME, ALARM. All transitions are evaluated at the clk edge; new state and outputs are visible the cycle after the request (latency 1).

Alarm start:
- Condition: alarm_match & alarm_en & ~stop_btn, from any state.
- Go to ALARM; second counter=0; gate=1.
- Preempts KEY and CHIME.
- alarm_match while already in ALARM is ignored; the counter is not restarted.
- alarm_match with alarm_en=0 is ignored.

ALARM:
- Each tick_1hz: toggle gate, increment second counter. This gives 1 s on / 1 s off, starting with on.
- Exit when the tick that brings the counter to ALARM_SECS arrives, or on stop_btn.
- Exit goes to CHIME if chime_req=1, else IDLE.
- stop_btn and tick in the same cycle: stop wins.
- chime_req and key_beep are ignored (dropped) while in ALARM.

CHIME:
- Entered from IDLE or KEY when chime_req=1; preempts KEY.
- gate follows chime_req, so the chime generator's on/off pattern passes through unchanged.
- Leaves to IDLE the cycle after chime_req is sampled low.
- stop_btn has no effect. key_beep is ignored.

KEY:
- Entered from IDLE on key_beep when chime_req=0; beep counter=0; gate=1.
- Stays for exactly BEEP_LEN cycles, then goes to IDLE.
- key_beep while in KEY restarts the beep counter.

Priority within one cycle: alarm start > chime_req > key_beep.

Tone generator:
- Divisor selected by state.
- Counter counts 0..DIV-1; at DIV-1 it wraps to 0 and the tone bit toggles.
- On any state change, counter=0 and tone bit=0.
- In IDLE the tone bit is held at 0.

Output:
- buzzer register = tone bit & gate, computed from the current-cycle values; buzzer lags by one cycle.
- buzzer is always 0 in IDLE.

Width rules:
- Tone counter sized for max(TONE_DIV_*)-1.
- Beep counter sized for BEEP_LEN.
- Second counter sized for ALARM_SECS.
- No overflow or wrap beyond the stated limits.

Test Plan:
Bench parameters: TONE_DIV_ALARM=4, TONE_DIV_CHIME=8, TONE_DIV_KEY=2, BEEP_LEN=10, ALARM_SECS=4; tick_1hz every 100 cycles.

1. Reset then key_beep pulse -> active_src=1 for exactly 10 cycles; buzzer toggles every 2 cycles while in KEY; then buzzer=0, active_src=0.
2. chime_req high 250 cycles -> active_src=2, buzzer period 16 cycles; returns to IDLE 1 cycle after chime_req low. A key_beep during this window is dropped.
3. alarm_match with alarm_en=1 -> alarm_ringing=1, buzzer period 8 cycles during on-seconds and silent during off-seconds. After 4 ticks, alarm_ringing=0 and active_src=0.
4. Alarm ringing, stop_btn after the 1st tick -> alarm_ringing=0 next cycle. With chime_req=1 at that time -> active_src=2.
5. During chime, alarm_match with alarm_en=1 -> ALARM preempts next cycle and the tone counter restarts. alarm_match with alarm_en=0 -> no change.
6. Assert rst mid-ALARM -> all outputs 0 next cycle; a subsequent tick does not resume the ring. alarm_match and stop_btn in the same cycle -> stays IDLE.
